// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: FSM state
// encoding, RISC-V load/store funct3 codes and the access-size decode.
package mem_ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_IF_RD  = 3'd1;
    localparam logic [2:0] ST_MEM_RD = 3'd2;
    localparam logic [2:0] ST_MEM_WR = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Number of RAM byte cycles for a MEM access; 0 marks an illegal funct3.
    function automatic logic [2:0] f3_nbytes(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return 3'd1;
            F3_LH, F3_LHU: return 3'd2;
            F3_LW:         return 3'd4;
            default:       return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester and RAM-side signal bundle of mem_ctrl. The master side is the
// pipeline plus the RAM; the slave side is the controller itself.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_rdy;
    logic [31:0]       if_inst;

    logic              mem_req;
    logic              mem_we;
    logic [2:0]        mem_funct3;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_rdy;
    logic [31:0]       mem_rdata;

    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    logic              stall_req;

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_funct3, mem_addr, mem_wdata, ram_din,
        input  if_rdy, if_inst, mem_rdy, mem_rdata, ram_a, ram_wr, ram_dout, stall_req
    );

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_funct3, mem_addr, mem_wdata, ram_din,
        output if_rdy, if_inst, mem_rdy, mem_rdata, ram_a, ram_wr, ram_dout, stall_req
    );

endinterface

// File: rtl/mem_ctrl_load_ext.sv
// Combinational RISC-V load extension of an assembled little-endian word.
module mem_ctrl_load_ext
    import mem_ctrl_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_word,
    output logic [31:0] o_ext
);

    // Sign- or zero-extend according to the load type; LW passes through.
    always_comb begin
        o_ext = i_word;
        case (i_funct3)
            F3_LB:   o_ext = {{24{i_word[7]}}, i_word[7:0]};
            F3_LH:   o_ext = {{16{i_word[15]}}, i_word[15:0]};
            F3_LBU:  o_ext = {24'h0, i_word[7:0]};
            F3_LHU:  o_ext = {16'h0, i_word[15:0]};
            default: o_ext = i_word;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial sequencer for the single 8-bit RAM port, shared between
// instruction fetch and the MEM stage (MEM has fixed priority).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for a request; MEM wins over IF
// ST_IF_RD  | fetching 4 bytes for IF, one address per cycle
// ST_MEM_RD | reading 1/2/4 bytes for a MEM load
// ST_MEM_WR | writing 1/2/4 bytes for a MEM store
// ST_DONE   | one-cycle rdy pulse; requests ignored
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic       clk,
    input logic       rst,
    mem_ctrl_if.slave bus
);

    logic [2:0]        r_state;
    logic [2:0]        r_cnt;
    logic [2:0]        r_nbytes;
    logic [2:0]        r_funct3;
    logic              r_is_mem;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_data;

    logic [ADDR_W-1:0] r_ram_a;
    logic              r_ram_wr;
    logic [7:0]        r_ram_dout;
    logic              r_if_rdy;
    logic [DATA_W-1:0] r_if_inst;
    logic              r_mem_rdy;
    logic [DATA_W-1:0] r_mem_rdata;

    logic [2:0]        w_req_nbytes;
    logic [2:0]        w_next_cnt;
    logic [1:0]        w_idx;
    logic [1:0]        w_wr_idx;
    logic [DATA_W-1:0] w_asm;
    logic [DATA_W-1:0] w_ext;

    assign w_req_nbytes = f3_nbytes(bus.mem_funct3);
    assign w_next_cnt   = r_cnt + 3'd1;
    // Read data lags its address by one cycle, so cycle r_cnt delivers byte r_cnt-1.
    assign w_idx        = r_cnt[1:0] - 2'd1;
    assign w_wr_idx     = w_next_cnt[1:0];

    // Word as it stands once the byte arriving this cycle is merged in.
    always_comb begin
        w_asm = r_data;
        w_asm[8*w_idx +: 8] = bus.ram_din;
    end

    mem_ctrl_load_ext u_load_ext (
        .i_funct3 (r_funct3),
        .i_word   (w_asm),
        .o_ext    (w_ext)
    );

    // Arbitration, per-byte sequencing and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_nbytes    <= '0;
            r_funct3    <= '0;
            r_is_mem    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_data      <= '0;
            r_ram_a     <= '0;
            r_ram_wr    <= 1'b0;
            r_ram_dout  <= '0;
            r_if_rdy    <= 1'b0;
            r_if_inst   <= '0;
            r_mem_rdy   <= 1'b0;
            r_mem_rdata <= '0;
        end else begin
            r_ram_a    <= '0;
            r_ram_wr   <= 1'b0;
            r_ram_dout <= '0;
            r_if_rdy   <= 1'b0;
            r_mem_rdy  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt  <= '0;
                    r_data <= '0;
                    if (bus.mem_req) begin
                        r_is_mem <= 1'b1;
                        r_addr   <= bus.mem_addr;
                        r_funct3 <= bus.mem_funct3;
                        r_wdata  <= bus.mem_wdata;
                        r_nbytes <= w_req_nbytes;
                        if (w_req_nbytes == 3'd0) begin
                            r_mem_rdy   <= 1'b1;
                            r_mem_rdata <= '0;
                            r_state     <= ST_DONE;
                        end else if (bus.mem_we) begin
                            r_ram_wr   <= 1'b1;
                            r_ram_a    <= bus.mem_addr;
                            r_ram_dout <= bus.mem_wdata[7:0];
                            r_state    <= ST_MEM_WR;
                        end else begin
                            r_ram_a <= bus.mem_addr;
                            r_state <= ST_MEM_RD;
                        end
                    end else if (bus.if_req) begin
                        r_is_mem <= 1'b0;
                        r_addr   <= bus.if_addr;
                        r_nbytes <= 3'd4;
                        r_ram_a  <= bus.if_addr;
                        r_state  <= ST_IF_RD;
                    end
                end
                ST_IF_RD, ST_MEM_RD: begin
                    if (r_cnt != 3'd0) begin
                        r_data[8*w_idx +: 8] <= bus.ram_din;
                    end
                    if (r_cnt == r_nbytes) begin
                        r_state <= ST_DONE;
                        if (r_is_mem) begin
                            r_mem_rdy   <= 1'b1;
                            r_mem_rdata <= w_ext;
                        end else begin
                            r_if_rdy  <= 1'b1;
                            r_if_inst <= w_asm;
                        end
                    end else begin
                        r_cnt <= w_next_cnt;
                        if (w_next_cnt < r_nbytes) begin
                            r_ram_a <= r_addr + ADDR_W'(w_next_cnt);
                        end
                    end
                end
                ST_MEM_WR: begin
                    if (w_next_cnt == r_nbytes) begin
                        r_mem_rdy <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt      <= w_next_cnt;
                        r_ram_wr   <= 1'b1;
                        r_ram_a    <= r_addr + ADDR_W'(w_next_cnt);
                        r_ram_dout <= r_wdata[8*w_wr_idx +: 8];
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ram_a     = r_ram_a;
    assign bus.ram_wr    = r_ram_wr;
    assign bus.ram_dout  = r_ram_dout;
    assign bus.if_rdy    = r_if_rdy;
    assign bus.if_inst   = r_if_inst;
    assign bus.mem_rdy   = r_mem_rdy;
    assign bus.mem_rdata = r_mem_rdata;
    assign bus.stall_req = ~rst & ((bus.mem_req & ~r_mem_rdy) | (bus.if_req & ~r_if_rdy));

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: expected RAM cycles and rdy/data results are
// queued when a request is driven and compared when the DUT produces them.
module tb_mem_ctrl;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
    } act_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rdy_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;

    act_t q_act[$];
    rdy_t q_if[$];
    rdy_t q_mem[$];

    logic [7:0]  ram     [0:1023];
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] exp_mrd;

    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic int nbytes_ref(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [31:0] ext_ref(input logic [2:0] f3, input logic [31:0] v);
        case (f3)
            3'b000:  return {{24{v[7]}}, v[7:0]};
            3'b001:  return {{16{v[15]}}, v[15:0]};
            3'b100:  return {24'h0, v[7:0]};
            3'b101:  return {16'h0, v[15:0]};
            default: return v;
        endcase
    endfunction

    // Byte RAM: data appears the cycle after its address.
    always @(posedge clk) begin
        bus.ram_din <= ram[bus.ram_a[9:0]];
        if (bus.ram_wr) ram[bus.ram_a[9:0]] <= bus.ram_dout;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Compare RAM activity and rdy pulses against the queued expectations.
    always @(negedge clk) begin : mon
        act_t a;
        rdy_t r;
        if (mon_en) begin
            while (q_act.size() > 0 && q_act[0].cyc < cyc) begin
                a = q_act.pop_front();
                chk("ram_cycle_missed", cyc, a.cyc);
            end
            if (q_act.size() > 0 && q_act[0].cyc == cyc) begin
                a = q_act.pop_front();
                chk("ram_a", bus.ram_a, a.a);
                chk("ram_wr", bus.ram_wr, a.wr);
                chk("ram_dout", bus.ram_dout, a.d);
            end else begin
                chk("ram_idle", {bus.ram_wr, bus.ram_dout, bus.ram_a}, 64'd0);
            end

            while (q_if.size() > 0 && q_if[0].cyc < cyc) begin
                r = q_if.pop_front();
                chk("if_rdy_missed", cyc, r.cyc);
            end
            if (bus.if_rdy) begin
                if (q_if.size() > 0 && q_if[0].cyc == cyc) begin
                    r = q_if.pop_front();
                    chk("if_inst", bus.if_inst, r.data);
                end else begin
                    chk("if_rdy_spurious", bus.if_rdy, 0);
                end
            end

            while (q_mem.size() > 0 && q_mem[0].cyc < cyc) begin
                r = q_mem.pop_front();
                chk("mem_rdy_missed", cyc, r.cyc);
            end
            if (bus.mem_rdy) begin
                if (q_mem.size() > 0 && q_mem[0].cyc == cyc) begin
                    r = q_mem.pop_front();
                    chk("mem_rdata", bus.mem_rdata, r.data);
                end else begin
                    chk("mem_rdy_spurious", bus.mem_rdy, 0);
                end
            end
        end
    end

    task automatic set_byte(input logic [9:0] a, input logic [7:0] v);
        ram[a] <= v;
        ref_mem[a] = v;
    endtask

    // Queue the RAM cycles and result of a MEM access starting in cycle t0.
    task automatic push_mem(input int t0, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd);
        int          n;
        logic [31:0] ak;
        logic [31:0] v;
        n = nbytes_ref(f3);
        v = '0;
        if (n == 0) begin
            exp_mrd = '0;
            q_mem.push_back(rdy_t'{t0 + 1, 32'h0});
        end else if (we) begin
            for (int k = 0; k < n; k++) begin
                ak = addr + k;
                q_act.push_back(act_t'{t0 + 1 + k, ak, 1'b1, wd[8*k +: 8]});
                ref_mem[ak[9:0]] = wd[8*k +: 8];
            end
            q_mem.push_back(rdy_t'{t0 + n + 1, exp_mrd});
        end else begin
            for (int k = 0; k < n; k++) begin
                ak = addr + k;
                q_act.push_back(act_t'{t0 + 1 + k, ak, 1'b0, 8'h00});
                v[8*k +: 8] = ref_mem[ak[9:0]];
            end
            exp_mrd = ext_ref(f3, v);
            q_mem.push_back(rdy_t'{t0 + n + 2, exp_mrd});
        end
    endtask

    task automatic push_if(input int t0, input logic [31:0] addr);
        logic [31:0] ak;
        logic [31:0] v;
        for (int k = 0; k < 4; k++) begin
            ak = addr + k;
            q_act.push_back(act_t'{t0 + 1 + k, ak, 1'b0, 8'h00});
            v[8*k +: 8] = ref_mem[ak[9:0]];
        end
        q_if.push_back(rdy_t'{t0 + 6, v});
    endtask

    task automatic do_mem(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        int t0;
        bit got;
        @(posedge clk); #1;
        t0 = cyc;
        bus.mem_req    = 1'b1;
        bus.mem_we     = we;
        bus.mem_funct3 = f3;
        bus.mem_addr   = addr;
        bus.mem_wdata  = wd;
        push_mem(t0, we, f3, addr, wd);
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            got = bus.mem_rdy;
            chk("mem_stall_req", bus.stall_req, !got);
            if (i == 1) begin
                bus.mem_addr  = $urandom;
                bus.mem_wdata = $urandom;
            end
        end
        chk("mem_done_in_time", got, 1);
        @(posedge clk); #1;
        bus.mem_req = 1'b0;
    endtask

    task automatic do_if(input logic [31:0] addr);
        int t0;
        bit got;
        @(posedge clk); #1;
        t0 = cyc;
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        push_if(t0, addr);
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            got = bus.if_rdy;
            chk("if_stall_req", bus.stall_req, !got);
            if (i == 1) bus.if_addr = $urandom;
        end
        chk("if_done_in_time", got, 1);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
    endtask

    initial begin
        int t0;
        bit md;
        bit id;
        logic [31:0] v;

        rst            = 1'b1;
        bus.if_req     = 1'b1;
        bus.if_addr    = '0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_funct3 = '0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        exp_mrd        = '0;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            set_byte(10'(i), v[7:0]);
        end
        set_byte(10'h100, 8'h13);
        set_byte(10'h101, 8'h05);
        set_byte(10'h102, 8'h10);
        set_byte(10'h103, 8'h00);
        set_byte(10'h010, 8'h80);
        set_byte(10'h030, 8'h00);
        set_byte(10'h031, 8'h80);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_if_rdy", bus.if_rdy, 0);
        chk("rst_if_inst", bus.if_inst, 0);
        chk("rst_mem_rdy", bus.mem_rdy, 0);
        chk("rst_mem_rdata", bus.mem_rdata, 0);
        chk("rst_ram", {bus.ram_wr, bus.ram_dout, bus.ram_a}, 64'd0);
        chk("rst_stall_req", bus.stall_req, 0);
        bus.if_req = 1'b0;
        rst        = 1'b0;
        mon_en     = 1'b1;

        do_if(32'h100);
        do_mem(1'b1, 3'b000, 32'h20, 32'hAABBCC80);
        do_mem(1'b0, 3'b000, 32'h10, 32'h0);
        do_mem(1'b0, 3'b100, 32'h10, 32'h0);
        do_mem(1'b0, 3'b001, 32'h30, 32'h0);
        do_mem(1'b0, 3'b101, 32'h30, 32'h0);
        do_mem(1'b0, 3'b000, 32'h20, 32'h0);
        do_mem(1'b1, 3'b001, 32'h23, 32'h00001234);
        do_mem(1'b0, 3'b010, 32'h22, 32'h0);
        do_mem(1'b0, 3'b011, 32'h50, 32'h0);
        do_mem(1'b1, 3'b110, 32'h50, 32'hFFFFFFFF);
        do_mem(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);
        do_mem(1'b1, 3'b010, 32'hFFFFFFFE, 32'h89ABCDEF);
        do_mem(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);

        // MEM store and IF fetch requested in the same cycle.
        @(posedge clk); #1;
        t0 = cyc;
        bus.mem_req    = 1'b1;
        bus.mem_we     = 1'b1;
        bus.mem_funct3 = 3'b010;
        bus.mem_addr   = 32'h40;
        bus.mem_wdata  = 32'h11223344;
        bus.if_req     = 1'b1;
        bus.if_addr    = 32'h0;
        push_mem(t0, 1'b1, 3'b010, 32'h40, 32'h11223344);
        push_if(t0 + 6, 32'h0);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk("both_stall_req", bus.stall_req, (i < 12));
            md = bus.mem_rdy;
            id = bus.if_rdy;
            @(posedge clk); #1;
            if (md) bus.mem_req = 1'b0;
            if (id) bus.if_req = 1'b0;
        end
        bus.mem_req = 1'b0;
        bus.if_req  = 1'b0;
        do_mem(1'b0, 3'b010, 32'h40, 32'h0);

        // Reset during the second byte of a word store.
        @(posedge clk); #1;
        t0 = cyc;
        bus.mem_req    = 1'b1;
        bus.mem_we     = 1'b1;
        bus.mem_funct3 = 3'b010;
        bus.mem_addr   = 32'h60;
        bus.mem_wdata  = 32'hDEADBEEF;
        push_mem(t0, 1'b1, 3'b001, 32'h60, 32'h0000BEEF);
        void'(q_mem.pop_back());
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst         = 1'b1;
        bus.mem_req = 1'b0;
        @(negedge clk);
        chk("rst_mid_stall_req", bus.stall_req, 0);
        @(posedge clk); #1;
        chk("rst_mid_mem_rdata", bus.mem_rdata, 0);
        chk("rst_mid_if_inst", bus.if_inst, 0);
        chk("rst_mid_mem_rdy", bus.mem_rdy, 0);
        rst     = 1'b0;
        exp_mrd = '0;
        do_mem(1'b1, 3'b000, 32'h70, 32'h0000005A);
        do_mem(1'b0, 3'b010, 32'h60, 32'h0);
        do_if(32'h100);

        repeat (4) @(posedge clk);
        #1;
        chk("queues_drained", q_act.size() + q_if.size() + q_mem.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Arbitrates and sequences the single byte-wide RAM port between instruction fetch (IF) and the MEM pipeline stage.
- Splits each 1/2/4-byte access into per-byte RAM cycles and assembles little-endian results.
- Applies RISC-V load sign/zero extension to MEM-stage reads.
- Raises a stall request toward the pipeline control while any accepted or pending access is incomplete.

Parameters:
ADDR_W, 32, width of byte addresses on all ports
DATA_W, 32, requester data width (fixed 4 bytes; other values unsupported)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
if_req  in  1  IF read request, held until if_rdy
if_addr  in  ADDR_W  IF fetch address
if_rdy  out  1  one-cycle pulse: if_inst valid, IF access done
if_inst  out  32  fetched word
mem_req  in  1  MEM-stage request, held until mem_rdy
mem_we  in  1  1=store, 0=load
mem_funct3  in  3  RISC-V load/store funct3
mem_addr  in  ADDR_W  MEM-stage byte address
mem_wdata  in  32  store data
mem_rdy  out  1  one-cycle pulse: MEM access done
mem_rdata  out  32  extended load result
ram_a  out  ADDR_W  RAM byte address
ram_wr  out  1  RAM write strobe
ram_dout  out  8  byte to RAM
ram_din  in  8  byte from RAM; valid the cycle after its address
stall_req  out  1  pipeline stall request

Behaviour:
- Reset (rst=1 at an edge): state IDLE, counters 0. All registered outputs are 0: ram_a, ram_wr, ram_dout, if_rdy, if_inst, mem_rdy, mem_rdata. Reset overrides any access in progress.
- Reset mid-operation: no further ram_wr. No rdy pulse for the aborted access. Bytes already written stay in RAM.
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- Arbitration in IDLE:
  - mem_req has fixed priority over if_req.
  - Request fields (addr, we, funct3, wdata) are captured at the accept edge. Later changes while busy are ignored.
- Byte count n from mem_funct3:
  - 000/100 → 1.
  - 001/101 → 2.
  - 010 → 4.
  - IF reads are always n=4.
- Illegal funct3 (011, 110, 111): no RAM activity. mem_rdy pulses in the cycle after accept, with mem_rdata=0.
- Timing: T0 is the cycle in which a request is sampled in IDLE.
- Read (IF_RD/MEM_RD):
  - ram_a=addr+k during T(1+k), k=0..n-1.
  - Byte k is taken from ram_din in T(2+k) and placed at bits [8k+7:8k].
  - rdy and data are presented in T(n+2) via the DONE state.
- Write (MEM_WR):
  - ram_wr=1, ram_a=addr+k, ram_dout=wdata[8k+7:8k] during T(1+k).
  - mem_rdy pulses in T(n+1) via DONE.
- DONE lasts exactly one cycle:
  - Requests are ignored in DONE.
  - Return to IDLE follows.
  - The next accept is possible in the following cycle.
- Load extension:
  - LB, LH: sign-extend from bit 7 / bit 15.
  - LBU, LHU: zero-extend.
  - LW: as assembled.
- if_inst and mem_rdata hold their last value until the next completion of the same requester.
- Address arithmetic is modulo 2^ADDR_W; wrap at the top of memory is silent. There is no alignment check; misaligned accesses proceed byte-wise.
- Outside active phases: ram_wr=0, ram_dout=0, ram_a=0.
- stall_req = (mem_req & ~mem_rdy) | (if_req & ~if_rdy), combinational, 0 during reset.
- Simultaneous requests: MEM is served first. IF is accepted in the IDLE cycle after MEM's DONE, provided if_req is still high.

Decomposition:
- Shared defs: the funct3 constants (LB/LH/LW/LBU/LHU, SB/SH/SW) and the state encoding.
- Natural sub-module: load_ext (funct3 + assembled word → extended result, combinational).

Test Plan:
- IF read: if_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00 → ram_a 0x100..0x103 in T1..T4; if_rdy in T6; if_inst=0x00100513.
- SB: mem_addr=0x20, wdata=0xAABBCC80 → single ram_wr at 0x20 with ram_dout=0x80 in T1; mem_rdy in T2.
- LB vs LBU of byte 0x80 → mem_rdata=0xFFFFFF80 vs 0x00000080. LH of 0x00,0x80 → 0xFFFF8000.
- Both requests in same T0 (SW to 0x40, IF to 0x0) → four writes first; IF accepted after DONE; stall_req stays high throughout.
- rst raised during T2 of a SW → no ram_wr from T3 on; no mem_rdy; outputs 0; a fresh request is then accepted normally.
- Illegal funct3=011 → no RAM activity; mem_rdy in T1 with mem_rdata=0.
